data_mem_arbiter: RTL

Arbitrates the single read/write port (port 0) of the vector data memory among several requesters:
- host input loader (writes only);
- MVP core memory controller (reads and writes);
- matrix-inversion writeback.

It performs round-robin arbitration with a starvation override and an optional burst lock. It drives the SRAM's active-low chip-select and write-enable, and returns one-cycle-latency read data to the requester that issued the read.

---
 rtl/data_mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Port-0 arbiter for the vector data memory: round-robin with a starvation
// override and burst lock, driving the SRAM strobes and routing read returns.
module data_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 512,
    parameter int MASK_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_WIDTH = $clog2(MAX_WAIT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_wmask,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvld,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_csb,
    output logic                             mem_web,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [MASK_WIDTH-1:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0]            mem_din,
    input  logic [DATA_WIDTH-1:0]            mem_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_SAT = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]        NREQ_EXT = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      lock_owner_r;
    logic                  lock_vld_r;
    logic [NUM_REQ-1:0]    rvld_r;
    logic [WAIT_WIDTH-1:0] wait_cnt [NUM_REQ];

    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [IDX_W:0]        rr_sum;
    logic [IDX_W-1:0]      rr_cand;

    // Later assignments override earlier ones: round-robin < starvation < lock.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        rr_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (rr_sum >= NREQ_EXT)
                rr_sum = rr_sum - NREQ_EXT;
            rr_cand = rr_sum[IDX_W-1:0];
            if (req[rr_cand]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_cand;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (wait_cnt[i] == WAIT_SAT))
                gnt_idx = IDX_W'(i);
        end
        if (lock_vld_r && req[lock_owner_r])
            gnt_idx = lock_owner_r;
        if (rst)
            gnt_any = 1'b0;
    end

    assign gnt_oh    = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign gnt       = gnt_oh;
    assign mem_csb   = ~gnt_any;
    assign mem_web   = ~(gnt_any & req_we[gnt_idx]);
    assign mem_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_din   = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign mem_wmask = req_wmask[gnt_idx*MASK_WIDTH +: MASK_WIDTH];
    assign rvld      = rvld_r;
    assign rdata     = mem_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            lock_vld_r   <= 1'b0;
            lock_owner_r <= '0;
            rvld_r       <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                wait_cnt[i] <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                lock_vld_r <= req_lock[gnt_idx];
                if (req_lock[gnt_idx])
                    lock_owner_r <= gnt_idx;
            end else if (lock_vld_r && !req[lock_owner_r]) begin
                lock_vld_r <= 1'b0;
            end
            rvld_r <= (gnt_any && !req_we[gnt_idx]) ? gnt_oh : '0;
            // Waiting requesters age until they saturate and win on priority.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !gnt_oh[i])
                    wait_cnt[i] <= (wait_cnt[i] == WAIT_SAT) ? WAIT_SAT : wait_cnt[i] + 1'b1;
                else
                    wait_cnt[i] <= '0;
            end
        end
    end

endmodule
